// File: rtl/axi4_stream_reg_slice_pkg.sv
// Shared types and sizing helpers for the AXI4-Stream register slice.
// Imported by the skid stage and the top-level slice.
package axi4_stream_reg_slice_pkg;

    // Occupancy of one 2-entry skid stage; the encoding doubles as the count value.
    typedef enum logic [1:0] {
        CNT_EMPTY = 2'd0,
        CNT_ONE   = 2'd1,
        CNT_FULL  = 2'd2
    } stage_cnt_e;

    // Bits in one packed beat: tdata, tlast, tstrb, tkeep, tid, tdest and tuser.
    function automatic int unsigned word_width(
        input int unsigned tdata_w,
        input int unsigned tid_w,
        input int unsigned tdest_w,
        input int unsigned tuser_w
    );
        return tdata_w + 1 + 2 * (tdata_w / 8) + tid_w + tdest_w + tuser_w;
    endfunction

    // Bits needed for level 0..2*stages; a single tied-off bit when there are no stages.
    function automatic int unsigned level_width(input int unsigned stages);
        return (stages == 0) ? 1 : $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/axi4_stream_reg_slice_if.sv
// AXI4-Stream bundle with every sideband field; master drives the beat, slave drives tready.
interface axi4_stream_if #(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH   = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1
);
    localparam int unsigned TSTRB_WIDTH = TDATA_WIDTH / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TSTRB_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );

endinterface

// File: rtl/axi4_stream_reg_slice_skid_stage.sv
// One full-throughput skid stage: 2-entry FIFO whose in_ready comes from a flop,
// so neither the forward nor the backward path passes through combinationally.
module axi4_stream_skid_stage
    import axi4_stream_reg_slice_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_word,
    output logic [1:0]            count_o
);

    stage_cnt_e            state;
    stage_cnt_e            state_nxt;
    logic [WORD_WIDTH-1:0] mem [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  ready_q;
    logic                  wr_en;
    logic                  rd_en;

    assign wr_en = in_valid & ready_q;
    assign rd_en = (state != CNT_EMPTY) & out_ready;

    // NOTE: every variable written in always_comb gets a default first, so no path
    // can leave it unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            CNT_EMPTY: if (wr_en) state_nxt = CNT_ONE;
            CNT_ONE: begin
                if (wr_en && !rd_en)      state_nxt = CNT_FULL;
                else if (!wr_en && rd_en) state_nxt = CNT_EMPTY;
            end
            CNT_FULL:  if (rd_en) state_nxt = CNT_ONE;
            default:   state_nxt = CNT_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= CNT_EMPTY;
            ready_q <= 1'b0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            // NOTE: the two entries are reset on purpose: the output word is the
            // oldest entry and must read as zero straight out of reset.
            mem[0]  <= '0;
            mem[1]  <= '0;
        end else begin
            state   <= state_nxt;
            ready_q <= (state_nxt != CNT_FULL);
            if (wr_en) begin
                mem[wr_ptr] <= in_word;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) rd_ptr <= ~rd_ptr;
        end
    end

    // ready_q mirrors (count != 2) but is held low through reset.
    assign in_ready  = ready_q;
    assign out_valid = (state != CNT_EMPTY);
    assign out_word  = mem[rd_ptr];
    assign count_o   = state;

endmodule

// File: rtl/axi4_stream_reg_slice.sv
// AXI4-Stream register slice: STAGES chained skid stages with occupancy report.
// Optional delivered-packet counter is built when AXI4_STREAM_REG_SLICE_PKT_CNT_EN is defined.
module axi4_stream_reg_slice
    import axi4_stream_reg_slice_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = 32,
    parameter int unsigned TID_WIDTH   = 1,
    parameter int unsigned TDEST_WIDTH = 1,
    parameter int unsigned TUSER_WIDTH = 1,
    parameter int unsigned STAGES      = 2,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    axi4_stream_if.slave                      pkt_i,
    axi4_stream_if.master                     pkt_o,
    output logic [level_width(STAGES)-1:0]    level_o
`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]              pkt_cnt_o
`endif
);

    localparam int unsigned WORD_W = word_width(TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);
    localparam int unsigned LVL_W  = level_width(STAGES);

    logic [WORD_W-1:0] in_word;
    logic [WORD_W-1:0] out_word;

    // tlast sits in the same word as its data, so it can never split from its beat.
    assign in_word = {pkt_i.tlast, pkt_i.tuser, pkt_i.tdest, pkt_i.tid,
                      pkt_i.tkeep, pkt_i.tstrb, pkt_i.tdata};
    assign {pkt_o.tlast, pkt_o.tuser, pkt_o.tdest, pkt_o.tid,
            pkt_o.tkeep, pkt_o.tstrb, pkt_o.tdata} = out_word;

    if (STAGES == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i | rst_i;
        assign out_word       = in_word;
        assign pkt_o.tvalid   = pkt_i.tvalid;
        assign pkt_i.tready   = pkt_o.tready;
        assign level_o        = LVL_W'(0);
    end else begin : g_chain
        logic [WORD_W-1:0] word  [STAGES+1];
        logic              valid [STAGES+1];
        logic              ready [STAGES+1];
        logic [1:0]        count [STAGES];

        assign valid[0]      = pkt_i.tvalid;
        assign word[0]       = in_word;
        assign pkt_i.tready  = ready[0];
        assign pkt_o.tvalid  = valid[STAGES];
        assign out_word      = word[STAGES];
        assign ready[STAGES] = pkt_o.tready;

        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            axi4_stream_skid_stage #(
                .WORD_WIDTH (WORD_W)
            ) u_stage (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .in_valid  (valid[k]),
                .in_ready  (ready[k]),
                .in_word   (word[k]),
                .out_valid (valid[k+1]),
                .out_ready (ready[k+1]),
                .out_word  (word[k+1]),
                .count_o   (count[k])
            );
        end

        // Sum of stage flops only; no input port reaches level_o.
        always_comb begin
            level_o = '0;
            for (int k = 0; k < STAGES; k++) begin
                level_o = level_o + LVL_W'(count[k]);
            end
        end
    end

`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
    // Wraps naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_o <= '0;
        end else if (pkt_o.tvalid && pkt_o.tready && pkt_o.tlast) begin
            pkt_cnt_o <= pkt_cnt_o + 1'b1;
        end
    end
`else
    localparam int unsigned UNUSED_CNT_WIDTH = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_axi4_stream_reg_slice.sv
// Scoreboard bench for axi4_stream_reg_slice (STAGES=3) plus a STAGES=0 pass-through instance.
module tb_axi4_stream_reg_slice;

    localparam int unsigned TDATA_W = 32;
    localparam int unsigned TID_W   = 2;
    localparam int unsigned TDEST_W = 3;
    localparam int unsigned TUSER_W = 4;
    localparam int unsigned STAGES  = 3;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned STRB_W  = TDATA_W / 8;
    localparam int unsigned LVL_W   = $clog2(2 * STAGES + 1);

    typedef struct packed {
        logic [TDATA_W-1:0] tdata;
        logic [STRB_W-1:0]  tstrb;
        logic [STRB_W-1:0]  tkeep;
        logic               tlast;
        logic [TID_W-1:0]   tid;
        logic [TDEST_W-1:0] tdest;
        logic [TUSER_W-1:0] tuser;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TUSER_WIDTH(TUSER_W)) s_in ();
    axi4_stream_if #(.TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TUSER_WIDTH(TUSER_W)) s_out ();
    axi4_stream_if #(.TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TUSER_WIDTH(TUSER_W)) b_in ();
    axi4_stream_if #(.TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W), .TUSER_WIDTH(TUSER_W)) b_out ();

    logic [LVL_W-1:0] level;
    logic [0:0]       b_level;
`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] b_pkt_cnt;
`endif

    axi4_stream_reg_slice #(
        .TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W),
        .TUSER_WIDTH(TUSER_W), .STAGES(STAGES), .CNT_WIDTH(CNT_W)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .pkt_i   (s_in),
        .pkt_o   (s_out),
        .level_o (level)
`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
        ,
        .pkt_cnt_o (pkt_cnt)
`endif
    );

    axi4_stream_reg_slice #(
        .TDATA_WIDTH(TDATA_W), .TID_WIDTH(TID_W), .TDEST_WIDTH(TDEST_W),
        .TUSER_WIDTH(TUSER_W), .STAGES(0), .CNT_WIDTH(CNT_W)
    ) dut_bypass (
        .clk_i   (clk),
        .rst_i   (rst),
        .pkt_i   (b_in),
        .pkt_o   (b_out),
        .level_o (b_level)
`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
        ,
        .pkt_cnt_o (b_pkt_cnt)
`endif
    );

    int unsigned n_checks  = 0;
    int unsigned n_pass    = 0;
    int unsigned out_beats = 0;
    beat_t       sb[$];
    logic        stall_q   = 1'b0;
    beat_t       stall_word;

    function automatic beat_t make_beat(input int unsigned i, input logic last);
        beat_t b;
        b.tdata = TDATA_W'(i * 32'h0101_0001 + 32'h5a);
        b.tstrb = STRB_W'(i * 7 + 1);
        b.tkeep = STRB_W'(~i);
        b.tlast = last;
        b.tid   = TID_W'(i >> 2);
        b.tdest = TDEST_W'(i * 3);
        b.tuser = TUSER_W'(i >> 1);
        return b;
    endfunction

    function automatic beat_t get_in();
        return {s_in.tdata, s_in.tstrb, s_in.tkeep, s_in.tlast, s_in.tid, s_in.tdest, s_in.tuser};
    endfunction

    function automatic beat_t get_out();
        return {s_out.tdata, s_out.tstrb, s_out.tkeep, s_out.tlast, s_out.tid, s_out.tdest, s_out.tuser};
    endfunction

    task automatic put_in(input beat_t b, input logic v);
        s_in.tvalid = v;
        s_in.tdata  = b.tdata;
        s_in.tstrb  = b.tstrb;
        s_in.tkeep  = b.tkeep;
        s_in.tlast  = b.tlast;
        s_in.tid    = b.tid;
        s_in.tdest  = b.tdest;
        s_in.tuser  = b.tuser;
    endtask

    // Scoreboard: push on input handshake, pop and compare on output handshake,
    // and require a stalled output to hold its beat.
    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                n_checks++;
                if (s_out.tvalid !== 1'b1 || get_out() !== stall_word)
                    $display("FAIL hold: tvalid=%b word=%h, required tvalid=1 word=%h",
                             s_out.tvalid, get_out(), stall_word);
                else n_pass++;
            end
            if (s_in.tvalid === 1'b1 && s_in.tready === 1'b1) sb.push_back(get_in());
            if (s_out.tvalid === 1'b1 && s_out.tready === 1'b1) begin
                beat_t exp;
                n_checks++;
                out_beats++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_extra: got %h, required no beat", get_out());
                end else begin
                    exp = sb.pop_front();
                    if (get_out() !== exp) $display("FAIL sb_data: got %h, required %h", get_out(), exp);
                    else n_pass++;
                end
            end
            stall_q    = (s_out.tvalid === 1'b1) && (s_out.tready !== 1'b1);
            stall_word = get_out();
        end
    end

    task automatic send(input beat_t b);
        int unsigned w    = 0;
        bit          done = 1'b0;
        put_in(b, 1'b1);
        while (!done && w < 100) begin
            @(negedge clk);
            done = (s_in.tready === 1'b1);
            @(posedge clk); #1;
            w++;
        end
        s_in.tvalid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: tready never high for %h", b);
        end
    endtask

    task automatic drain(input string name);
        int unsigned w = 0;
        while (sb.size() != 0 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_drain: %0d beats left, required 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        s_out.tready = 1'b1;
        put_in(make_beat(0, 1'b1), 1'b1);
        repeat (4) begin
            @(negedge clk);
            n_checks += 3;
            if (s_out.tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b, required 0", s_out.tvalid); else n_pass++;
            if (level !== '0) $display("FAIL rst_level: got %0d, required 0", level); else n_pass++;
            if (s_in.tready !== 1'b0) $display("FAIL rst_tready: got %b, required 0", s_in.tready); else n_pass++;
        end
        n_checks++;
        if (get_out() !== '0) $display("FAIL rst_payload: got %h, required 0", get_out()); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (s_in.tready !== 1'b1) $display("FAIL rst_release_tready: got %b, required 1", s_in.tready); else n_pass++;
        @(posedge clk); #1;
        s_in.tvalid = 1'b0;
        drain("reset");
        n_checks++;
        if (out_beats != 1) $display("FAIL rst_first_beat: got %0d beats, required 1", out_beats); else n_pass++;
    endtask

    task automatic test_streaming();
        int unsigned acc = 0, outs = 0, cyc = 0, stalls = 0;
        int unsigned acc0_cyc = 0, first_out = 0, last_out = 0;
        s_out.tready = 1'b1;
        while ((acc < 100 || outs < 100) && cyc < 400) begin
            if (acc < 100) put_in(make_beat(acc, (acc % 8) == 7), 1'b1);
            else s_in.tvalid = 1'b0;
            @(negedge clk);
            if (s_in.tvalid === 1'b1) begin
                if (s_in.tready === 1'b1) begin
                    if (acc == 0) acc0_cyc = cyc;
                    acc++;
                end else if (acc > 0) stalls++;
            end
            if (s_out.tvalid === 1'b1 && s_out.tready === 1'b1) begin
                if (outs == 0) first_out = cyc;
                last_out = cyc;
                outs++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_in.tvalid = 1'b0;
        n_checks += 4;
        if (outs != 100) $display("FAIL stream_count: got %0d, required 100", outs); else n_pass++;
        if (first_out - acc0_cyc != STAGES)
            $display("FAIL stream_latency: got %0d, required %0d", first_out - acc0_cyc, STAGES); else n_pass++;
        if (last_out - first_out != 99) $display("FAIL stream_bubbles: span %0d, required 99", last_out - first_out); else n_pass++;
        if (stalls != 0) $display("FAIL stream_in_stall: got %0d, required 0", stalls); else n_pass++;
    endtask

    task automatic test_backpressure();
        int unsigned acc = 0;
        s_out.tready = 1'b0;
        for (int c = 0; c < 20; c++) begin
            put_in(make_beat(200 + acc, acc == 5), 1'b1);
            @(negedge clk);
            if (s_in.tvalid === 1'b1 && s_in.tready === 1'b1) acc++;
            @(posedge clk); #1;
        end
        s_in.tvalid = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (acc != 2 * STAGES) $display("FAIL bp_accepted: got %0d, required %0d", acc, 2 * STAGES); else n_pass++;
        if (level !== LVL_W'(2 * STAGES)) $display("FAIL bp_level: got %0d, required %0d", level, 2 * STAGES); else n_pass++;
        if (s_in.tready !== 1'b0) $display("FAIL bp_tready: got %b, required 0", s_in.tready); else n_pass++;
        @(posedge clk); #1;
        s_out.tready = 1'b1;
        for (int k = 0; k <= 2 * STAGES; k++) begin
            @(negedge clk);
            n_checks++;
            if (level !== LVL_W'(2 * STAGES - k))
                $display("FAIL bp_drain_level: got %0d, required %0d", level, 2 * STAGES - k);
            else n_pass++;
            @(posedge clk); #1;
        end
        drain("bp");
    endtask

    task automatic test_random();
        int unsigned sent = 0, cyc = 0, start = out_beats;
        logic        cur_valid = 1'b0;
        while (sent < 10000 && cyc < 60000) begin
            if (!cur_valid) cur_valid = 1'($urandom_range(0, 1));
            put_in(make_beat(sent + 1000, (sent % 7) == 6), cur_valid);
            s_out.tready = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            if (s_in.tvalid === 1'b1 && s_in.tready === 1'b1) begin
                sent++;
                cur_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_in.tvalid  = 1'b0;
        s_out.tready = 1'b1;
        drain("random");
        n_checks += 2;
        if (sent != 10000) $display("FAIL rand_sent: got %0d, required 10000", sent); else n_pass++;
        if (out_beats - start != 10000) $display("FAIL rand_out: got %0d, required 10000", out_beats - start); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int unsigned acc = 0, start;
        s_out.tready = 1'b0;
        for (int c = 0; c < 50 && acc < 4; c++) begin
            put_in(make_beat(5000 + acc, acc == 3), 1'b1);
            @(negedge clk);
            if (s_in.tvalid === 1'b1 && s_in.tready === 1'b1) acc++;
            @(posedge clk); #1;
        end
        s_in.tvalid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (level !== LVL_W'(4)) $display("FAIL mid_pre_level: got %0d, required 4", level); else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks += 2;
        if (s_out.tvalid !== 1'b0) $display("FAIL mid_tvalid: got %b, required 0", s_out.tvalid); else n_pass++;
        if (level !== '0) $display("FAIL mid_level: got %0d, required 0", level); else n_pass++;
        @(posedge clk); #1;
        start        = out_beats;
        s_out.tready = 1'b1;
        for (int i = 0; i < 5; i++) send(make_beat(6000 + i, i == 4));
        drain("mid");
        n_checks++;
        if (out_beats - start != 5) $display("FAIL mid_fresh: got %0d beats, required 5", out_beats - start); else n_pass++;
    endtask

`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
    task automatic test_pkt_cnt();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pkt_cnt !== '0) $display("FAIL cnt_reset: got %0d, required 0", pkt_cnt); else n_pass++;
        @(posedge clk); #1;
        s_out.tready = 1'b1;
        for (int i = 0; i < 17; i++) send(make_beat(7000 + i, 1'b1));
        drain("cnt");
        @(negedge clk);
        n_checks++;
        if (pkt_cnt !== CNT_W'(1)) $display("FAIL cnt_wrap: got %0d, required 1", pkt_cnt); else n_pass++;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_passthrough();
        for (int i = 0; i < 8; i++) begin
            beat_t b;
            logic  v, r;
            b = make_beat($urandom, 1'($urandom_range(0, 1)));
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            b_in.tvalid  = v;
            b_in.tdata   = b.tdata;
            b_in.tstrb   = b.tstrb;
            b_in.tkeep   = b.tkeep;
            b_in.tlast   = b.tlast;
            b_in.tid     = b.tid;
            b_in.tdest   = b.tdest;
            b_in.tuser   = b.tuser;
            b_out.tready = r;
            #1;
            n_checks += 3;
            if ({b_out.tdata, b_out.tstrb, b_out.tkeep, b_out.tlast, b_out.tid, b_out.tdest, b_out.tuser} !== b
                || b_out.tvalid !== v)
                $display("FAIL bypass_fwd: got %b/%h, required %b/%h", b_out.tvalid,
                         {b_out.tdata, b_out.tstrb, b_out.tkeep, b_out.tlast, b_out.tid, b_out.tdest, b_out.tuser}, v, b);
            else n_pass++;
            if (b_in.tready !== r) $display("FAIL bypass_ready: got %b, required %b", b_in.tready, r); else n_pass++;
            if (b_level !== 1'b0) $display("FAIL bypass_level: got %0d, required 0", b_level); else n_pass++;
            #4;
        end
    endtask

    initial begin
        s_in.tvalid  = 1'b0;
        s_out.tready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef AXI4_STREAM_REG_SLICE_PKT_CNT_EN
        test_pkt_cnt();
`endif
        test_passthrough();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
